// File: rtl/fpu_div_pkg.sv
// -----------------------------------------------------------------------------
// fpu_div_pkg
//
// Shared definitions for the FPUDiv request sequencer.
//   FP_W        : IEEE-754 single-precision word width.
//   META_TAG_W  : tag width carried in the packed metadata types. The
//                 sequencer's TAG_W parameter must match it.
//   div_meta_t  : {tag, dbz} tracked per in-flight operation.
//   div_rsp_t   : {data, meta} held in the result buffer.
//   is_zero()   : true for +0.0 and -0.0 (sign bit ignored).
// -----------------------------------------------------------------------------
package fpu_div_pkg;

    localparam int FP_W       = 32;
    localparam int META_TAG_W = 4;

    typedef struct packed {
        logic [META_TAG_W-1:0] tag;
        logic                  dbz;
    } div_meta_t;

    typedef struct packed {
        logic [FP_W-1:0] data;
        div_meta_t       meta;
    } div_rsp_t;

    // Exponent and mantissa all zero; the sign bit does not matter.
    function automatic logic is_zero(input logic [FP_W-1:0] fp);
        return (fp[FP_W-2:0] == '0);
    endfunction

endpackage : fpu_div_pkg

// File: rtl/fpu_div_fifo.sv
// -----------------------------------------------------------------------------
// fpu_div_fifo
//
// Synchronous show-ahead FIFO. The head entry is visible on head_data whenever
// empty is low; pop advances to the next entry. Push while full and pop while
// empty are ignored. Push and pop in the same cycle are both honoured.
//
// Ports
//   aclk, areset : clock, synchronous active-high reset (empties the FIFO)
//   push         : write push_data this cycle
//   push_data    : WIDTH-bit entry to store
//   pop          : discard the head entry this cycle
//   head_data    : current head entry (undefined while empty)
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module fpu_div_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule : fpu_div_fifo

// File: rtl/fpu_div_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_div_sequencer
//
// Sits in front of the FPUDiv core. Accepts tagged requests on a valid/ready
// port, issues operands to the divider's valid-only streams, re-attaches tags
// to returning results in order, and buffers results so the consumer may
// stall.
//
// Handshake rule on both req_* and rsp_*: a transfer happens on a rising edge
// where valid and ready are both high; once valid is raised the source holds
// its payload until that transfer.
//
// Ports
//   aclk, areset           : clock, synchronous active-high reset
//   req_valid/ready        : request handshake
//   req_a, req_b, req_tag  : dividend, divisor, opaque tag
//   s_axis_{a,b}_tdata     : registered operands to the divider
//   s_axis_{a,b}_tvalid    : one-cycle issue pulse (identical on both)
//   m_axis_result_tvalid   : divider result pulse (cannot be stalled)
//   m_axis_result_tdata    : divider quotient
//   rsp_valid/ready        : response handshake (show-ahead buffer head)
//   rsp_data, rsp_tag      : quotient and originating tag
//   rsp_dbz                : divisor was +/-0
//   inflight               : credits in use (divider + result buffer)
//   err_orphan             : sticky, a result arrived with no tag pending
// -----------------------------------------------------------------------------
module fpu_div_sequencer
    import fpu_div_pkg::*;
#(
    parameter int TAG_W = META_TAG_W,
    parameter int DEPTH = 8,
    parameter int DRAIN = 32
) (
    input  logic                     aclk,
    input  logic                     areset,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [FP_W-1:0]          req_a,
    input  logic [FP_W-1:0]          req_b,
    input  logic [TAG_W-1:0]         req_tag,

    output logic [FP_W-1:0]          s_axis_a_tdata,
    output logic                     s_axis_a_tvalid,
    output logic [FP_W-1:0]          s_axis_b_tdata,
    output logic                     s_axis_b_tvalid,

    input  logic                     m_axis_result_tvalid,
    input  logic [FP_W-1:0]          m_axis_result_tdata,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [FP_W-1:0]          rsp_data,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_dbz,

    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err_orphan
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int DCW = $clog2(DRAIN) + 1;

    // -------------------------------------------------------------------------
    // Drain FSM: after reset the divider may still hold operations from before
    // the reset, so its results are swallowed until the window expires.
    // -------------------------------------------------------------------------
    typedef enum logic {
        DRAINING = 1'b0,
        RUN      = 1'b1
    } drain_state_t;

    drain_state_t   state;
    drain_state_t   state_nxt;
    logic [DCW-1:0] drain_cnt;
    logic [DCW-1:0] drain_cnt_nxt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= DRAINING;
            drain_cnt <= DCW'(DRAIN - 1);
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            DRAINING: begin
                if (drain_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    drain_cnt_nxt = drain_cnt - DCW'(1);
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = DRAINING;
            end
        endcase
    end

    logic drain_done;
    assign drain_done = (state == RUN);

    // -------------------------------------------------------------------------
    // Handshakes and result routing
    // -------------------------------------------------------------------------
    logic      tag_full;
    logic      tag_empty;
    logic      rsp_full;
    logic      rsp_empty;
    div_meta_t tag_in;
    div_meta_t tag_head;
    div_rsp_t  rsp_in;
    div_rsp_t  rsp_head;
    logic      accept;
    logic      rsp_fire;
    logic      res_take;
    logic      tag_pop;
    logic      orphan;

    // The FIFO full flags can never be set while credits remain (occupancy of
    // either FIFO is bounded by inflight); gating on them only guards against
    // a misbehaving divider that emits extra results.
    assign req_ready = !areset && drain_done && (inflight < CW'(DEPTH))
                       && !tag_full && !rsp_full;
    assign accept    = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Results are only attributed to a request once the drain window closes.
    assign res_take  = drain_done && m_axis_result_tvalid;
    assign tag_pop   = res_take && !tag_empty;
    assign orphan    = res_take && tag_empty;

    assign tag_in.tag = req_tag;
    assign tag_in.dbz = is_zero(req_b);

    assign rsp_in.data = m_axis_result_tdata;
    assign rsp_in.meta = tag_head;

    fpu_div_fifo #(
        .WIDTH ($bits(div_meta_t)),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (accept),
        .push_data (tag_in),
        .pop       (tag_pop),
        .head_data (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fpu_div_fifo #(
        .WIDTH ($bits(div_rsp_t)),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (tag_pop),
        .push_data (rsp_in),
        .pop       (rsp_fire),
        .head_data (rsp_head),
        .full      (rsp_full),
        .empty     (rsp_empty)
    );

    // Payload is forced to zero while empty so the outputs are defined out of
    // reset even though the FIFO storage is not cleared.
    assign rsp_valid = !rsp_empty;
    assign rsp_data  = rsp_valid ? rsp_head.data     : '0;
    assign rsp_tag   = rsp_valid ? rsp_head.meta.tag : '0;
    assign rsp_dbz   = rsp_valid ? rsp_head.meta.dbz : 1'b0;

    // -------------------------------------------------------------------------
    // Credit counter
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            inflight <= '0;
        end else begin
            case ({accept, rsp_fire})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Operand issue: one-cycle valid pulse, data held until the next accept.
    // -------------------------------------------------------------------------
    logic op_valid;

    always_ff @(posedge aclk) begin
        if (areset) begin
            op_valid       <= 1'b0;
            s_axis_a_tdata <= '0;
            s_axis_b_tdata <= '0;
        end else begin
            op_valid <= accept;
            if (accept) begin
                s_axis_a_tdata <= req_a;
                s_axis_b_tdata <= req_b;
            end
        end
    end

    assign s_axis_a_tvalid = op_valid;
    assign s_axis_b_tvalid = op_valid;

    // -------------------------------------------------------------------------
    // Sticky orphan-result flag
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_orphan <= 1'b0;
        end else if (orphan) begin
            err_orphan <= 1'b1;
        end
    end

endmodule : fpu_div_sequencer
